// File: rtl/queue_ptrs_pkg.sv
// queue_ptrs_pkg: default depths, count-width helper and recovery FSM
// states shared by the IQ/ROB pointer tracker and its ring sub-block.
package queue_ptrs_pkg;

    localparam int QENTRIES_DEF = 8;
    localparam int QSLOTS_DEF   = 2;
    localparam int RENTRIES_DEF = 16;
    localparam int RSLOTS_DEF   = 2;
    localparam int CSLOTS_DEF   = 2;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_SCAN,
        RS_APPLY
    } rec_state_e;

endpackage

// File: rtl/queue_ptrs_ring_ptr.sv
// queue_ptrs_ring_ptr: one circular queue's tail set, head and free count.
// Ports: i_clk/i_rst (sync, active-high), i_enq/i_cmt (already-legal counts),
//   i_ld (reload tails from i_ld_base), i_ld_empty (reload tails at new head),
//   o_tails, o_head, o_free.
module queue_ptrs_ring_ptr
    import queue_ptrs_pkg::*;
#(
    parameter int DEPTH = QENTRIES_DEF,
    parameter int SLOTS = QSLOTS_DEF,
    parameter int ECW   = cnt_w(QSLOTS_DEF),
    parameter int CCW   = cnt_w(CSLOTS_DEF),
    parameter int PW    = $clog2(DEPTH),
    parameter int FW    = cnt_w(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ECW-1:0]           i_enq,
    input  logic [CCW-1:0]           i_cmt,
    input  logic                     i_ld,
    input  logic                     i_ld_empty,
    input  logic [PW-1:0]            i_ld_base,
    output logic [SLOTS-1:0][PW-1:0] o_tails,
    output logic [PW-1:0]            o_head,
    output logic [FW-1:0]            o_free
);

    // One spare bit so ptr+count never overflows for non-power-of-2 depths.
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] DEP_S = SW'(DEPTH);
    localparam logic [FW-1:0] DEP_F = FW'(DEPTH);

    logic [SLOTS-1:0][PW-1:0] r_tails;
    logic [SLOTS-1:0][PW-1:0] w_tails_n;
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            w_head_n;
    logic [PW-1:0]            w_base;
    logic [FW-1:0]            r_free;
    logic [FW-1:0]            w_free_n;
    logic [SW-1:0]            w_dist;

    // Sum is always < 2*DEPTH, so one conditional subtract is a full mod.
    function automatic logic [PW-1:0] wrap(input logic [SW-1:0] s);
        return (s >= DEP_S) ? PW'(s - DEP_S) : PW'(s);
    endfunction

    assign w_head_n = wrap({1'b0, r_head} + SW'(i_cmt));
    assign w_base   = i_ld_empty ? w_head_n : i_ld_base;

    // Occupancy after a reload: (base - head') mod DEPTH.
    assign w_dist = (w_base >= w_head_n)
                  ? {1'b0, w_base} - {1'b0, w_head_n}
                  : {1'b0, w_base} + DEP_S - {1'b0, w_head_n};

    always_comb begin
        w_tails_n = r_tails;
        w_free_n  = r_free - FW'(i_enq) + FW'(i_cmt);
        if (i_ld || i_ld_empty) begin
            w_free_n = DEP_F - FW'(w_dist);
            for (int j = 0; j < SLOTS; j++)
                w_tails_n[j] = wrap({1'b0, w_base} + SW'(j % DEPTH));
        end else begin
            for (int j = 0; j < SLOTS; j++)
                w_tails_n[j] = wrap({1'b0, r_tails[j]} + SW'(i_enq));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < SLOTS; j++)
                r_tails[j] <= PW'(j % DEPTH);
            r_head <= '0;
            r_free <= DEP_F;
        end else begin
            r_tails <= w_tails_n;
            r_head  <= w_head_n;
            r_free  <= w_free_n;
        end
    end

    assign o_tails = r_tails;
    assign o_head  = r_head;
    assign o_free  = r_free;

endmodule

// File: rtl/queue_ptrs.sv
// queue_ptrs: IQ and ROB head/tail/free tracking with branch-miss recovery.
// Ports: clk_i, rst_i (sync, active-high), branchmiss, iq_stomp, iq_br_tag,
//   iq_rid, queuedCnt, rqueuedCnt, iq_cmtCnt, rob_cmtCnt in; iq_tails,
//   rob_tails, iq_head, rob_head, iq_free, rob_free, can_queue, active_tag,
//   recover_busy, ovf_err out.
// Build option: define QPTR_PIPE_RECOVERY_EN for a two-cycle
//   SCAN/APPLY recovery; otherwise recovery completes in the miss cycle.
module queue_ptrs
    import queue_ptrs_pkg::*;
#(
    parameter int QENTRIES = QENTRIES_DEF,
    parameter int QSLOTS   = QSLOTS_DEF,
    parameter int RENTRIES = RENTRIES_DEF,
    parameter int RSLOTS   = RSLOTS_DEF,
    parameter int CSLOTS   = CSLOTS_DEF,
    parameter int QBITS    = $clog2(QENTRIES),
    parameter int RBITS    = $clog2(RENTRIES)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             branchmiss,
    input  logic [QENTRIES-1:0]              iq_stomp,
    input  logic [QENTRIES-1:0][QBITS-1:0]   iq_br_tag,
    input  logic [QENTRIES-1:0][RBITS-1:0]   iq_rid,
    input  logic [$clog2(QSLOTS+1)-1:0]      queuedCnt,
    input  logic [$clog2(RSLOTS+1)-1:0]      rqueuedCnt,
    input  logic [$clog2(CSLOTS+1)-1:0]      iq_cmtCnt,
    input  logic [$clog2(CSLOTS+1)-1:0]      rob_cmtCnt,
    output logic [QSLOTS-1:0][QBITS-1:0]     iq_tails,
    output logic [RSLOTS-1:0][RBITS-1:0]     rob_tails,
    output logic [QBITS-1:0]                 iq_head,
    output logic [RBITS-1:0]                 rob_head,
    output logic [$clog2(QENTRIES+1)-1:0]    iq_free,
    output logic [$clog2(RENTRIES+1)-1:0]    rob_free,
    output logic [$clog2(QSLOTS+1)-1:0]      can_queue,
    output logic [QBITS-1:0]                 active_tag,
    output logic                             recover_busy,
    output logic                             ovf_err
);

    localparam int QEW = cnt_w(QSLOTS);
    localparam int REW = cnt_w(RSLOTS);
    localparam int CCW = cnt_w(CSLOTS);
    localparam int QFW = cnt_w(QENTRIES);
    localparam int RFW = cnt_w(RENTRIES);

    logic             w_recov;
    logic             w_busy;
    logic             w_ld;
    logic             w_ld_empty;
    logic [QBITS-1:0] w_ld_q;
    logic [RBITS-1:0] w_ld_r;
    logic [QBITS-1:0] w_ld_tag;

    logic [QEW-1:0]   w_q_enq;
    logic [REW-1:0]   w_r_enq;
    logic [CCW-1:0]   w_q_cmt;
    logic [CCW-1:0]   w_r_cmt;
    logic             w_err;
    int               w_q_occ;
    int               w_r_occ;
    int               w_cq;

    logic             w_found;
    logic             w_all;
    logic [QBITS-1:0] w_n;

    logic [QBITS-1:0] r_active;
    logic             r_ovf;

    // Illegal counts are clamped to what the queue can take; enqueues
    // are dropped outright while a recovery is rewriting the tails.
    always_comb begin
        w_q_occ = QENTRIES - int'(iq_free);
        w_r_occ = RENTRIES - int'(rob_free);
        w_q_enq = queuedCnt;
        w_r_enq = rqueuedCnt;
        w_q_cmt = iq_cmtCnt;
        w_r_cmt = rob_cmtCnt;
        w_err   = 1'b0;
        if (w_recov) begin
            w_q_enq = '0;
            w_r_enq = '0;
        end else begin
            if (int'(queuedCnt) > int'(iq_free)) begin
                w_q_enq = QEW'(iq_free);
                w_err   = 1'b1;
            end
            if (int'(rqueuedCnt) > int'(rob_free)) begin
                w_r_enq = REW'(rob_free);
                w_err   = 1'b1;
            end
        end
        if (int'(iq_cmtCnt) > w_q_occ) begin
            w_q_cmt = CCW'(w_q_occ);
            w_err   = 1'b1;
        end
        if (int'(rob_cmtCnt) > w_r_occ) begin
            w_r_cmt = CCW'(w_r_occ);
            w_err   = 1'b1;
        end
    end

    // First stomped entry: a set bit whose circular predecessor is clear.
    // Later (higher) edges overwrite earlier ones.
    always_comb begin
        w_found = 1'b0;
        w_n     = '0;
        for (int n = 0; n < QENTRIES; n++) begin
            if (iq_stomp[n] && !iq_stomp[(n + QENTRIES - 1) % QENTRIES]) begin
                w_found = 1'b1;
                w_n     = QBITS'(n);
            end
        end
    end

    // All-ones has no edge: every entry is squashed, both queues drain.
    assign w_all = &iq_stomp;

`ifdef QPTR_PIPE_RECOVERY_EN
    rec_state_e       r_state;
    rec_state_e       w_state_n;
    logic             r_found;
    logic             r_all;
    logic [QBITS-1:0] r_n;
    logic [QBITS-1:0] r_tag;
    logic [RBITS-1:0] r_rid;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= RS_IDLE;
        else
            r_state <= w_state_n;
    end

    // APPLY always applies; a miss seen there just re-enters SCAN.
    always_comb begin
        w_state_n  = r_state;
        w_busy     = 1'b0;
        w_ld       = 1'b0;
        w_ld_empty = 1'b0;
        unique case (r_state)
            RS_IDLE: begin
                if (branchmiss)
                    w_state_n = RS_SCAN;
            end
            RS_SCAN: begin
                w_busy    = 1'b1;
                w_state_n = branchmiss ? RS_SCAN : RS_APPLY;
            end
            RS_APPLY: begin
                w_busy     = 1'b1;
                w_ld       = r_found;
                w_ld_empty = r_all;
                w_state_n  = branchmiss ? RS_SCAN : RS_IDLE;
            end
            default: w_state_n = RS_IDLE;
        endcase
    end

    // Stomp vector is sampled in SCAN; the last SCAN cycle's view wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_found <= 1'b0;
            r_all   <= 1'b0;
            r_n     <= '0;
            r_tag   <= '0;
            r_rid   <= '0;
        end else if (r_state == RS_SCAN) begin
            r_found <= w_found;
            r_all   <= w_all;
            r_n     <= w_n;
            r_tag   <= iq_br_tag[w_n];
            r_rid   <= iq_rid[w_n];
        end
    end

    assign w_recov  = branchmiss || w_busy;
    assign w_ld_q   = r_n;
    assign w_ld_r   = r_rid;
    assign w_ld_tag = r_tag;
`else
    assign w_busy     = 1'b0;
    assign w_recov    = branchmiss;
    assign w_ld       = branchmiss && w_found;
    assign w_ld_empty = branchmiss && w_all;
    assign w_ld_q     = w_n;
    assign w_ld_r     = iq_rid[w_n];
    assign w_ld_tag   = iq_br_tag[w_n];
`endif

    queue_ptrs_ring_ptr #(
        .DEPTH (QENTRIES),
        .SLOTS (QSLOTS),
        .ECW   (QEW),
        .CCW   (CCW),
        .PW    (QBITS),
        .FW    (QFW)
    ) u_iq (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_enq      (w_q_enq),
        .i_cmt      (w_q_cmt),
        .i_ld       (w_ld),
        .i_ld_empty (w_ld_empty),
        .i_ld_base  (w_ld_q),
        .o_tails    (iq_tails),
        .o_head     (iq_head),
        .o_free     (iq_free)
    );

    queue_ptrs_ring_ptr #(
        .DEPTH (RENTRIES),
        .SLOTS (RSLOTS),
        .ECW   (REW),
        .CCW   (CCW),
        .PW    (RBITS),
        .FW    (RFW)
    ) u_rob (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_enq      (w_r_enq),
        .i_cmt      (w_r_cmt),
        .i_ld       (w_ld),
        .i_ld_empty (w_ld_empty),
        .i_ld_base  (w_ld_r),
        .o_tails    (rob_tails),
        .o_head     (rob_head),
        .o_free     (rob_free)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_ld)
                r_active <= w_ld_tag;
            if (w_err)
                r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_cq = QSLOTS;
        if (int'(iq_free) < w_cq)
            w_cq = int'(iq_free);
        if (int'(rob_free) < w_cq)
            w_cq = int'(rob_free);
        can_queue = w_busy ? '0 : QEW'(w_cq);
    end

    assign active_tag   = r_active;
    assign ovf_err      = r_ovf;
    assign recover_busy = w_busy;

endmodule

// File: tb/tb_queue_ptrs.sv
// tb_queue_ptrs: directed and randomized checks of queue_ptrs against an
// occupancy-based reference model (tail = head + occupancy).
module tb_queue_ptrs;

    localparam int Q = 8;
    localparam int R = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i, branchmiss;
    logic [7:0]      iq_stomp;
    logic [7:0][2:0] iq_br_tag;
    logic [7:0][3:0] iq_rid;
    logic [1:0]      queuedCnt, rqueuedCnt, iq_cmtCnt, rob_cmtCnt;
    logic [1:0][2:0] iq_tails;
    logic [1:0][3:0] rob_tails;
    logic [2:0]      iq_head, active_tag;
    logic [3:0]      rob_head, iq_free;
    logic [4:0]      rob_free;
    logic [1:0]      can_queue;
    logic            recover_busy, ovf_err;

    // Six-entry IQ instance for the non-power-of-2 wrap case.
    logic [5:0]      s_stomp;
    logic [5:0][2:0] s_tag;
    logic [5:0][3:0] s_rid;
    logic [1:0]      s_q, s_rq, s_qc, s_rc;
    logic [1:0][2:0] s_tails;
    logic [1:0][3:0] s_rtails;
    logic [2:0]      s_head, s_free, s_atag;
    logic [3:0]      s_rhead;
    logic [4:0]      s_rfree;
    logic [1:0]      s_cq;
    logic            s_busy, s_ovf;

    queue_ptrs dut (
        .clk_i(clk), .rst_i(rst_i), .branchmiss(branchmiss),
        .iq_stomp(iq_stomp), .iq_br_tag(iq_br_tag), .iq_rid(iq_rid),
        .queuedCnt(queuedCnt), .rqueuedCnt(rqueuedCnt),
        .iq_cmtCnt(iq_cmtCnt), .rob_cmtCnt(rob_cmtCnt),
        .iq_tails(iq_tails), .rob_tails(rob_tails),
        .iq_head(iq_head), .rob_head(rob_head),
        .iq_free(iq_free), .rob_free(rob_free),
        .can_queue(can_queue), .active_tag(active_tag),
        .recover_busy(recover_busy), .ovf_err(ovf_err)
    );

    queue_ptrs #(.QENTRIES(6)) dut6 (
        .clk_i(clk), .rst_i(rst_i), .branchmiss(1'b0),
        .iq_stomp(s_stomp), .iq_br_tag(s_tag), .iq_rid(s_rid),
        .queuedCnt(s_q), .rqueuedCnt(s_rq),
        .iq_cmtCnt(s_qc), .rob_cmtCnt(s_rc),
        .iq_tails(s_tails), .rob_tails(s_rtails),
        .iq_head(s_head), .rob_head(s_rhead),
        .iq_free(s_free), .rob_free(s_rfree),
        .can_queue(s_cq), .active_tag(s_atag),
        .recover_busy(s_busy), .ovf_err(s_ovf)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: head and occupancy per queue.
    int m_qh, m_qo, m_rh, m_ro, m_tag;
    bit m_err;

    task automatic model_reset();
        m_qh = 0; m_qo = 0; m_rh = 0; m_ro = 0; m_tag = 0; m_err = 0;
    endtask

    task automatic model_step();
        int qe, re, qc, rc, n;
        bit fnd;
        if (rst_i) begin
            model_reset();
            return;
        end
        qe = int'(queuedCnt);
        re = int'(rqueuedCnt);
        qc = int'(iq_cmtCnt);
        rc = int'(rob_cmtCnt);
        if (qc > m_qo) begin qc = m_qo; m_err = 1; end
        if (rc > m_ro) begin rc = m_ro; m_err = 1; end
        if (!branchmiss) begin
            if (qe > Q - m_qo) begin qe = Q - m_qo; m_err = 1; end
            if (re > R - m_ro) begin re = R - m_ro; m_err = 1; end
        end
        m_qh = (m_qh + qc) % Q;
        m_rh = (m_rh + rc) % R;
        if (branchmiss) begin
            if (iq_stomp == 8'hFF) begin
                m_qo = 0;
                m_ro = 0;
            end else begin
                fnd = 0;
                n = 0;
                for (int i = 0; i < Q; i++)
                    if (iq_stomp[i] && !iq_stomp[(i + Q - 1) % Q]) begin
                        fnd = 1;
                        n = i;
                    end
                if (fnd) begin
                    m_qo  = (n - m_qh + Q) % Q;
                    m_ro  = (int'(iq_rid[n]) - m_rh + R) % R;
                    m_tag = int'(iq_br_tag[n]);
                end else begin
                    m_qo = m_qo - qc;
                    m_ro = m_ro - rc;
                end
            end
        end else begin
            m_qo = m_qo + qe - qc;
            m_ro = m_ro + re - rc;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rst_i = 0; branchmiss = 0; iq_stomp = '0;
        iq_br_tag = '0; iq_rid = '0;
        queuedCnt = 0; rqueuedCnt = 0; iq_cmtCnt = 0; rob_cmtCnt = 0;
        s_stomp = '0; s_tag = '0; s_rid = '0;
        s_q = 0; s_rq = 0; s_qc = 0; s_rc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        cyc();
        rst_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1; branchmiss = 1; iq_stomp = 8'h0F;
        queuedCnt = 2; rqueuedCnt = 2; iq_cmtCnt = 1;
        cyc();
        idle_inputs();
        total++; if (iq_tails !== {3'd1, 3'd0}) begin bad++; $display("FAIL reset_iq_tails got=%h exp=%h", iq_tails, {3'd1, 3'd0}); end
        total++; if (rob_tails !== {4'd1, 4'd0}) begin bad++; $display("FAIL reset_rob_tails got=%h exp=%h", rob_tails, {4'd1, 4'd0}); end
        total++; if (iq_head !== 0 || rob_head !== 0) begin bad++; $display("FAIL reset_heads got=%0d/%0d exp=0/0", iq_head, rob_head); end
        total++; if (iq_free !== 8 || rob_free !== 16) begin bad++; $display("FAIL reset_free got=%0d/%0d exp=8/16", iq_free, rob_free); end
        total++; if (can_queue !== 2) begin bad++; $display("FAIL reset_can_queue got=%0d exp=2", can_queue); end
        total++; if (active_tag !== 0 || recover_busy !== 0 || ovf_err !== 0) begin bad++; $display("FAIL reset_flags got=%0d/%0d/%0d exp=0/0/0", active_tag, recover_busy, ovf_err); end
    endtask

    task automatic test_fill();
        do_reset();
        queuedCnt = 2; rqueuedCnt = 2;
        repeat (4) cyc();
        idle_inputs();
        total++; if (iq_tails !== {3'd1, 3'd0}) begin bad++; $display("FAIL fill_iq_tails got=%h exp=%h", iq_tails, {3'd1, 3'd0}); end
        total++; if (iq_free !== 0) begin bad++; $display("FAIL fill_iq_free got=%0d exp=0", iq_free); end
        total++; if (can_queue !== 0) begin bad++; $display("FAIL fill_can_queue got=%0d exp=0", can_queue); end
        total++; if (rob_tails !== {4'd9, 4'd8}) begin bad++; $display("FAIL fill_rob_tails got=%h exp=%h", rob_tails, {4'd9, 4'd8}); end
        total++; if (rob_free !== 8) begin bad++; $display("FAIL fill_rob_free got=%0d exp=8", rob_free); end
        total++; if (ovf_err !== 0) begin bad++; $display("FAIL fill_ovf got=%0d exp=0", ovf_err); end
    endtask

    task automatic test_branchmiss();
        do_reset();
        queuedCnt = 2; rqueuedCnt = 2;
        repeat (2) cyc();
        queuedCnt = 0; rqueuedCnt = 0; iq_cmtCnt = 1; rob_cmtCnt = 1;
        cyc();
        idle_inputs();
        for (int i = 0; i < Q; i++) begin
            iq_rid[i]    = 4'($urandom_range(0, 15));
            iq_br_tag[i] = 3'($urandom_range(0, 7));
        end
        iq_rid[3] = 4'd11; iq_br_tag[3] = 3'd5;
        branchmiss = 1; iq_stomp = 8'b0011_1000; queuedCnt = 2;
        cyc();
        idle_inputs();
        total++; if (iq_tails !== {3'd4, 3'd3}) begin bad++; $display("FAIL bm_iq_tails got=%h exp=%h", iq_tails, {3'd4, 3'd3}); end
        total++; if (rob_tails !== {4'd12, 4'd11}) begin bad++; $display("FAIL bm_rob_tails got=%h exp=%h", rob_tails, {4'd12, 4'd11}); end
        total++; if (active_tag !== 5) begin bad++; $display("FAIL bm_tag got=%0d exp=5", active_tag); end
        total++; if (iq_free !== 6 || iq_head !== 1) begin bad++; $display("FAIL bm_iq_free_head got=%0d/%0d exp=6/1", iq_free, iq_head); end
        total++; if (rob_free !== 6) begin bad++; $display("FAIL bm_rob_free got=%0d exp=6", rob_free); end
    endtask

    task automatic test_stomp_all_zero();
        do_reset();
        queuedCnt = 2;
        repeat (2) cyc();
        queuedCnt = 0; iq_cmtCnt = 2;
        cyc();
        idle_inputs();
        branchmiss = 1; iq_stomp = 8'hFF; iq_cmtCnt = 1; queuedCnt = 2;
        cyc();
        idle_inputs();
        total++; if (iq_tails !== {3'd4, 3'd3} || iq_head !== 3) begin bad++; $display("FAIL all_iq_tails got=%h head=%0d exp=%h head=3", iq_tails, iq_head, {3'd4, 3'd3}); end
        total++; if (iq_free !== 8 || rob_free !== 16) begin bad++; $display("FAIL all_free got=%0d/%0d exp=8/16", iq_free, rob_free); end
        total++; if (rob_tails !== {4'd1, 4'd0}) begin bad++; $display("FAIL all_rob_tails got=%h exp=%h", rob_tails, {4'd1, 4'd0}); end
        branchmiss = 1; iq_stomp = 8'h00; queuedCnt = 2; rqueuedCnt = 2;
        cyc();
        idle_inputs();
        total++; if (iq_tails !== {3'd4, 3'd3} || iq_free !== 8) begin bad++; $display("FAIL zero_hold got=%h free=%0d exp=%h free=8", iq_tails, iq_free, {3'd4, 3'd3}); end
        total++; if (rob_tails !== {4'd1, 4'd0} || ovf_err !== 0) begin bad++; $display("FAIL zero_rob_hold got=%h ovf=%0d exp=%h ovf=0", rob_tails, ovf_err, {4'd1, 4'd0}); end
    endtask

    task automatic test_overflow();
        do_reset();
        queuedCnt = 2;
        repeat (3) cyc();
        queuedCnt = 1;
        cyc();
        total++; if (iq_tails !== {3'd0, 3'd7} || iq_free !== 1 || ovf_err !== 0) begin bad++; $display("FAIL ovf_pre got=%h free=%0d ovf=%0d exp=%h free=1 ovf=0", iq_tails, iq_free, ovf_err, {3'd0, 3'd7}); end
        queuedCnt = 2;
        cyc();
        idle_inputs();
        total++; if (iq_tails !== {3'd1, 3'd0} || iq_free !== 0) begin bad++; $display("FAIL ovf_clamp got=%h free=%0d exp=%h free=0", iq_tails, iq_free, {3'd1, 3'd0}); end
        total++; if (ovf_err !== 1) begin bad++; $display("FAIL ovf_set got=%0d exp=1", ovf_err); end
        repeat (3) cyc();
        total++; if (ovf_err !== 1) begin bad++; $display("FAIL ovf_sticky got=%0d exp=1", ovf_err); end
        do_reset();
        total++; if (ovf_err !== 0) begin bad++; $display("FAIL ovf_rst got=%0d exp=0", ovf_err); end
        iq_cmtCnt = 1;
        cyc();
        idle_inputs();
        total++; if (iq_head !== 0 || iq_free !== 8 || ovf_err !== 1) begin bad++; $display("FAIL cmt_ovf head=%0d free=%0d ovf=%0d exp=0/8/1", iq_head, iq_free, ovf_err); end
    endtask

    task automatic test_wrap6();
        do_reset();
        s_q = 2;
        repeat (2) cyc();
        s_q = 1;
        cyc();
        total++; if (s_tails !== {3'd0, 3'd5} || s_free !== 1) begin bad++; $display("FAIL wrap6_pre got=%h free=%0d exp=%h free=1", s_tails, s_free, {3'd0, 3'd5}); end
        s_q = 1; s_qc = 2;
        cyc();
        idle_inputs();
        total++; if (s_tails !== {3'd1, 3'd0}) begin bad++; $display("FAIL wrap6_tails got=%h exp=%h", s_tails, {3'd1, 3'd0}); end
        total++; if (s_head !== 2 || s_free !== 2 || s_ovf !== 0) begin bad++; $display("FAIL wrap6_head_free head=%0d free=%0d ovf=%0d exp=2/2/0", s_head, s_free, s_ovf); end
    endtask

    task automatic test_random();
        int st, ln, e, cq;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_i      = ($urandom_range(0, 99) == 0);
            branchmiss = ($urandom_range(0, 5) == 0);
            queuedCnt  = 2'($urandom_range(0, 2));
            rqueuedCnt = 2'($urandom_range(0, 2));
            iq_cmtCnt  = 2'($urandom_range(0, 2));
            rob_cmtCnt = 2'($urandom_range(0, 2));
            for (int i = 0; i < Q; i++) begin
                iq_rid[i]    = 4'($urandom_range(0, 15));
                iq_br_tag[i] = 3'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 3))
                0: iq_stomp = 8'h00;
                1: iq_stomp = 8'hFF;
                2: begin
                    st = $urandom_range(0, 7);
                    ln = $urandom_range(1, 7);
                    iq_stomp = '0;
                    for (int k = 0; k < ln; k++) iq_stomp[(st + k) % Q] = 1'b1;
                end
                default: iq_stomp = 8'($urandom);
            endcase
            cyc();
            for (int j = 0; j < 2; j++) begin
                e = (m_qh + m_qo + j) % Q;
                total++; if (int'(iq_tails[j]) != e) begin bad++; $display("FAIL rnd_iq_tail%0d cyc=%0d got=%0d exp=%0d", j, c, iq_tails[j], e); end
                e = (m_rh + m_ro + j) % R;
                total++; if (int'(rob_tails[j]) != e) begin bad++; $display("FAIL rnd_rob_tail%0d cyc=%0d got=%0d exp=%0d", j, c, rob_tails[j], e); end
            end
            total++; if (int'(iq_head) != m_qh || int'(rob_head) != m_rh) begin bad++; $display("FAIL rnd_heads cyc=%0d got=%0d/%0d exp=%0d/%0d", c, iq_head, rob_head, m_qh, m_rh); end
            total++; if (int'(iq_free) != Q - m_qo || int'(rob_free) != R - m_ro) begin bad++; $display("FAIL rnd_free cyc=%0d got=%0d/%0d exp=%0d/%0d", c, iq_free, rob_free, Q - m_qo, R - m_ro); end
            cq = 2;
            if (Q - m_qo < cq) cq = Q - m_qo;
            if (R - m_ro < cq) cq = R - m_ro;
            total++; if (int'(can_queue) != cq) begin bad++; $display("FAIL rnd_can_queue cyc=%0d got=%0d exp=%0d", c, can_queue, cq); end
            total++; if (int'(active_tag) != m_tag) begin bad++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", c, active_tag, m_tag); end
            total++; if (ovf_err !== m_err || recover_busy !== 1'b0) begin bad++; $display("FAIL rnd_flags cyc=%0d ovf=%0d busy=%0d exp=%0d/0", c, ovf_err, recover_busy, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fill();
        test_branchmiss();
        test_stomp_all_zero();
        test_overflow();
        test_wrap6();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/queue_ptrs.md
Name: queue_ptrs

Overview:
- Parametrised successor to the issue-queue/ROB tail-pointer logic in the nvio3 core.
- Tracks head and tail pointers plus occupancy for both the issue queue (IQ) and the reorder buffer (ROB).
- Advances tails on enqueue and heads on commit, reports free space and slot-level queue permission to dispatch, and restores tails after a branch miss from the IQ stomp vector.
- Sits between the dispatch/queue logic and commit.

Parameters:
- QENTRIES, 8: IQ depth; any value ≥2, not required to be a power of 2.
- QSLOTS, 2: IQ tail pointers produced (max enqueues per cycle).
- RENTRIES, 16: ROB depth; any value ≥2.
- RSLOTS, 2: ROB tail pointers produced.
- CSLOTS, 2: max commits per cycle.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- branchmiss  in  1  recovery request
- iq_stomp  in  QENTRIES  squashed IQ entries
- iq_br_tag  in  QBITS x QENTRIES  branch tag per IQ entry
- iq_rid  in  RBITS x QENTRIES  ROB id per IQ entry
- queuedCnt  in  $clog2(QSLOTS+1)  IQ entries enqueued this cycle
- rqueuedCnt  in  $clog2(RSLOTS+1)  ROB entries enqueued this cycle
- iq_cmtCnt  in  $clog2(CSLOTS+1)  IQ entries retired
- rob_cmtCnt  in  $clog2(CSLOTS+1)  ROB entries retired
- iq_tails  out  QBITS x QSLOTS  IQ tail pointers
- rob_tails  out  RBITS x RSLOTS  ROB tail pointers
- iq_head, rob_head  out  QBITS / RBITS  oldest entry
- iq_free, rob_free  out  $clog2(QENTRIES+1) / $clog2(RENTRIES+1)  free entries
- can_queue  out  $clog2(QSLOTS+1)  min(iq_free, rob_free, QSLOTS)
- active_tag  out  QBITS  branch tag of first stomped entry
- recover_busy  out  1  recovery in progress
- ovf_err  out  1  sticky protocol error

Behaviour:
- Reset values:
  - iq_tails[n]=n, rob_tails[n]=n.
  - Heads=0, iq_free=QENTRIES, rob_free=RENTRIES.
  - can_queue=min(QSLOTS,QENTRIES,RENTRIES); active_tag=0; recover_busy=0; ovf_err=0.
  - Reset overrides everything, including an in-flight recovery.
- Normal cycle (no recovery):
  - tails[n] <= (tails[n]+cnt) mod ENTRIES.
  - head <= (head+cmt) mod ENTRIES.
  - free <= free - cnt + cmt.
  - All registered, 1-cycle latency.
- Modulus is computed by conditional subtract; the unsigned sum is widened by one bit so there is no overflow for non-power-of-2 depths.
- Protocol errors:
  - Condition: enqueue > free, or commit > occupied (ENTRIES-free).
  - Response: the offending count is clamped to the legal value and ovf_err sets, sticky until reset.
- Recovery scan:
  - First stomped index n = entry with iq_stomp[n] & ~iq_stomp[(n+QENTRIES-1) mod QENTRIES].
  - If several edges exist, the highest n wins.
  - iq_tails[j] <= (n+j) mod QENTRIES.
  - rob_tails[j] <= (iq_rid[n]+j) mod RENTRIES.
  - active_tag <= iq_br_tag[n].
  - iq_free <= QENTRIES - ((n - head') mod QENTRIES); rob_free is computed likewise from iq_rid[n], with head' = head after this cycle's commit.
- Recovery edge cases:
  - branchmiss with iq_stomp all zero: tails, free counts and active_tag hold; commits still apply.
  - iq_stomp all ones: both queues become empty; tails = head', free = ENTRIES.
  - Enqueue counts are ignored during any recovery cycle; commits are always honoured.
- can_queue is combinational from the registered free counts.

Optional Feature:
- Macro: QPTR_PIPE_RECOVERY_EN.
- When defined, recovery takes two cycles, driven by a state machine IDLE->SCAN->APPLY->IDLE:
  - SCAN registers n, iq_rid[n] and iq_br_tag[n].
  - APPLY updates tails, free counts and active_tag.
  - recover_busy=1 in SCAN and APPLY, and can_queue is forced to 0.
  - branchmiss arriving in SCAN restarts SCAN; in APPLY it is queued and SCAN follows immediately.
- When undefined, recovery completes in the branchmiss cycle and recover_busy is tied 0.

Decomposition:
- nvio3-defines.sv holds QBITS, RBITS, the default depths and a count-width localparam helper.
- Sub-module ring_ptr (parametrised depth/slots): owns one tail set, head and free count, with a recovery-load input.
- queue_ptrs instantiates ring_ptr twice and contains the stomp-edge scan, the clamp/error logic and the optional recovery FSM.

Test Plan:
- Reset, then queuedCnt=2 and rqueuedCnt=2 for 4 cycles → iq_tails={0,1}, iq_free=0, can_queue=0, rob_tails={8,9}, rob_free=8.
- Wrap: with QENTRIES=6, tails={5,0} and queuedCnt=1 → tails={0,1}; iq_cmtCnt=2 in the same cycle → head advances by 2 and free is net +1.
- Branchmiss with iq_stomp=8'b0011_1000, iq_rid[3]=11, iq_br_tag[3]=5, head=1 → iq_tails={3,4}, rob_tails={11,12}, active_tag=5, iq_free=6.
- Branchmiss with iq_stomp all ones plus iq_cmtCnt=1, head=2 → iq_tails={3,4}, iq_free=8; with iq_stomp=0 → tails hold.
- queuedCnt=2 with iq_free=1 → tail advances by 1 and ovf_err=1, which persists until rst_i.
- With QPTR_PIPE_RECOVERY_EN: branchmiss at cycle t → recover_busy=1 at t+1 and t+2, tails update at t+2, can_queue=0 throughout; rst_i at t+1 → reset values at t+2.
